l_lock_ctrl: RTL

// - Password-lock controller: sequences the 7-seg display block via Current_State/Error_Times/Code.
// - Takes debounced single-cycle key pulses from the keypad scanner.
// - Captures 4-digit entries, compares against a stored password and counts failures.
// - Times the UNLOCK/ERROR/ALARM screens and lets the admin change the password.

---
 rtl/l_lock_ctrl_pkg.sv | 29 ++
 rtl/l_lock_timer.sv | 30 +++
 rtl/l_lock_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/l_lock_ctrl_pkg.sv
// Shared encodings for the password lock: FSM states as seen by the display
// block, the blank digit code and a small digit-insert helper.
package l_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_INPUT  = 3'd1,
    ST_UNLOCK = 3'd2,
    ST_ERROR  = 3'd3,
    ST_ALARM  = 3'd4,
    ST_ADMIN  = 3'd5
  } lock_state_e;

  localparam logic [3:0]  BLANK      = 4'hA;
  localparam logic [15:0] CODE_BLANK = {4{BLANK}};
  localparam int          NUM_DIGITS = 4;

  // Write digit d into nibble idx of the entry; idx >= NUM_DIGITS leaves it untouched.
  function automatic logic [15:0] put_digit(input logic [15:0] code,
                                            input logic [2:0]  idx,
                                            input logic [3:0]  d);
    logic [15:0] r;
    r = code;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == 3'(i)) r[4*i +: 4] = d;
    return r;
  endfunction

endpackage

// File: rtl/l_lock_timer.sv
// Loadable down-counter shared by every timed screen. Stops at zero and
// raises zero until the next load.
module l_lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; hold at zero once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/l_lock_ctrl.sv
// Password-lock controller: collects 4-digit entries, checks them against
// the stored password, counts failures and times the result screens.
module l_lock_ctrl
  import l_lock_ctrl_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PWD = 16'h4321,
  parameter int unsigned MAX_ERR     = 3,
  parameter int unsigned UNLOCK_CYC  = 100000000,
  parameter int unsigned ERROR_CYC   = 50000000,
  parameter int unsigned ALARM_CYC   = 500000000,
  parameter int unsigned IDLE_CYC    = 500000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic        KEY_ENTER,
  input  logic        KEY_CLEAR,
  input  logic        KEY_ADMIN,
  output logic [2:0]  Current_State,
  output logic [3:0]  Error_Times,
  output logic [15:0] Code,
  output logic        UNLOCK_O,
  output logic        ALARM_O
);

  localparam int unsigned MAX_AB  = (UNLOCK_CYC > ERROR_CYC) ? UNLOCK_CYC : ERROR_CYC;
  localparam int unsigned MAX_CD  = (ALARM_CYC > IDLE_CYC) ? ALARM_CYC : IDLE_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int          TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  // Loading N-1 keeps a screen visible for exactly N cycles.
  localparam logic [TW-1:0] LD_UNLOCK = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] LD_ERROR  = TW'(ERROR_CYC - 1);
  localparam logic [TW-1:0] LD_ALARM  = TW'(ALARM_CYC - 1);
  localparam logic [TW-1:0] LD_IDLE   = TW'(IDLE_CYC - 1);

  lock_state_e   state_q, state_d;
  logic [3:0]    err_q, err_d, err_inc;
  logic [15:0]   code_q, code_d;
  logic [15:0]   pwd_q, pwd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          unlock_q, alarm_q;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          k_clr, k_ent, k_dig, full;

  l_lock_timer #(.W(TW)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Key priority: CLEAR over ENTER over digit; out-of-range digits never count.
  always_comb begin
    k_clr = KEY_CLEAR;
    k_ent = KEY_ENTER & ~KEY_CLEAR;
    k_dig = KEY_VALID & ~KEY_CLEAR & ~KEY_ENTER & (KEY_CODE <= 4'd9);
    full  = (cnt_q == 3'(NUM_DIGITS));
  end

  // Next-state, entry buffer, failure count and timer control.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    pwd_d    = pwd_q;
    tmr_load = 1'b0;
    tmr_val  = LD_IDLE;
    err_inc  = (err_q < 4'(MAX_ERR)) ? err_q + 4'd1 : err_q;

    case (state_q)
      ST_WAIT: begin
        if (k_dig) begin
          state_d  = ST_INPUT;
          code_d   = put_digit(CODE_BLANK, 3'd0, KEY_CODE);
          cnt_d    = 3'd1;
          tmr_load = 1'b1;
        end
      end
      ST_INPUT, ST_ADMIN: begin
        if (k_clr) begin
          code_d   = CODE_BLANK;
          cnt_d    = 3'd0;
          tmr_load = 1'b1;
        end else if (k_ent && full) begin
          tmr_load = 1'b1;
          if (state_q == ST_ADMIN) begin
            pwd_d   = code_q;
            state_d = ST_WAIT;
          end else if (code_q == pwd_q) begin
            state_d = ST_UNLOCK;
            err_d   = 4'd0;
            tmr_val = LD_UNLOCK;
          end else begin
            err_d = err_inc;
            if (err_inc == 4'(MAX_ERR)) begin
              state_d = ST_ALARM;
              tmr_val = LD_ALARM;
            end else begin
              state_d = ST_ERROR;
              tmr_val = LD_ERROR;
            end
          end
        end else if (k_dig && !full) begin
          code_d   = put_digit(code_q, cnt_q, KEY_CODE);
          cnt_d    = cnt_q + 3'd1;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_WAIT;
        end
      end
      ST_UNLOCK: begin
        if (KEY_ADMIN) begin
          state_d  = ST_ADMIN;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_WAIT;
        end
      end
      ST_ERROR: begin
        if (tmr_zero) begin
          state_d  = ST_INPUT;
          tmr_load = 1'b1;
        end
      end
      ST_ALARM: begin
        if (tmr_zero) begin
          state_d = ST_WAIT;
          err_d   = 4'd0;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Any exit from a non-WAIT state starts the next screen with an empty entry.
    if (state_d != state_q && state_q != ST_WAIT) begin
      code_d = CODE_BLANK;
      cnt_d  = 3'd0;
    end
  end

  // State, entry, password and registered output drives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_WAIT;
      err_q    <= 4'd0;
      code_q   <= CODE_BLANK;
      cnt_q    <= 3'd0;
      pwd_q    <= DEFAULT_PWD;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      pwd_q    <= pwd_d;
      unlock_q <= (state_d == ST_UNLOCK);
      alarm_q  <= (state_d == ST_ALARM);
    end
  end

  assign Current_State = state_q;
  assign Error_Times   = err_q;
  assign Code          = code_q;
  assign UNLOCK_O      = unlock_q;
  assign ALARM_O       = alarm_q;

endmodule
